// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the CPU/DMA memory bus arbiter.
//   state_t      : arbiter FSM state (IDLE, OWN_CPU, OWN_DMA)
//   owner_t      : owner encoding used for the tie-break history (CPU=0, DMA=1)
//   BUS_W        : address/data width of every bus in the arbiter
//   LOCK_MAX_DEF : default forced-release limit, one 2048-word frame copy
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int BUS_W        = 16;
    localparam int LOCK_MAX_DEF = 2048;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundle of the two requester ports, the memory-controller port and the
// lock_timeout pulse.
//   slave  : the arbiter side (takes requests, drives gnt/rvalid/rdata/mem_*)
//   master : the environment side (CPU, DMA and memory controller)
//
// Handshake: a requester raises x_req (with x_we, x_addr, x_wdata, x_lock) and
// holds x_addr/x_wdata stable until x_gnt is high. Every cycle with
// x_req=1 and x_gnt=1 is one issued access; x_gnt is combinational from the
// registered owner state and x_req. For a read issued in cycle N, x_rvalid is
// high in cycle N+1 with x_rdata taken from mem_rdata; x_rdata holds its last
// value otherwise. Writes produce no rvalid.
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;

    logic                           cpu_req;
    logic                           cpu_we;
    logic                           cpu_lock;
    logic [mem_arb_pkg::BUS_W-1:0]  cpu_addr;
    logic [mem_arb_pkg::BUS_W-1:0]  cpu_wdata;
    logic                           cpu_gnt;
    logic                           cpu_rvalid;
    logic [mem_arb_pkg::BUS_W-1:0]  cpu_rdata;

    logic                           dma_req;
    logic                           dma_we;
    logic                           dma_lock;
    logic [mem_arb_pkg::BUS_W-1:0]  dma_addr;
    logic [mem_arb_pkg::BUS_W-1:0]  dma_wdata;
    logic                           dma_gnt;
    logic                           dma_rvalid;
    logic [mem_arb_pkg::BUS_W-1:0]  dma_rdata;

    logic                           mem_en;
    logic                           mem_we;
    logic [mem_arb_pkg::BUS_W-1:0]  mem_addr;
    logic [mem_arb_pkg::BUS_W-1:0]  mem_wdata;
    logic [mem_arb_pkg::BUS_W-1:0]  mem_rdata;

    logic                           lock_timeout;

    modport slave (
        input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output lock_timeout
    );

    modport master (
        output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  lock_timeout
    );

endinterface

// File: rtl/mem_arb_lock_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_lock_timer
// Counts consecutive locked cycles of the current owner and flags when the
// current cycle is the LOCK_MAX-th one. Only built with
// MEM_ARB_LOCK_TIMEOUT_EN defined.
//   CLK, RESET : clock, synchronous active-high reset
//   clear_i    : owner changes after this cycle, or arbiter is idle
//   lock_i     : current owner holds its lock hint this cycle
//   expired_o  : this locked cycle reaches LOCK_MAX
// -----------------------------------------------------------------------------
module mem_arb_lock_timer #(
    parameter int LOCK_MAX = 2048
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear_i,
    input  logic lock_i,
    output logic expired_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // cnt_q is the number of locked cycles already spent in this ownership,
    // so the current cycle is number cnt_q+1.
    assign expired_o = lock_i && ((int'(cnt_q) + 1) >= LOCK_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !lock_i) begin
            cnt_d = '0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Two-requester (CPU, frame-copy DMA) arbiter in front of a single memory
// controller, with ownership locking and alternating tie-break.
//   CLK, RESET : clock, synchronous active-high reset
//   bus_io     : mem_bus_arbiter_if.slave (requester ports, memory port,
//                lock_timeout pulse)
//   state_o    : current FSM state, for observation
// Optional feature: define MEM_ARB_LOCK_TIMEOUT_EN to force a locked owner off
// the bus after LOCK_MAX consecutive locked cycles when the other side waits.
// Without it the lock is honoured indefinitely and lock_timeout is 0.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    mem_bus_arbiter_if.slave bus_io,
    output state_t           state_o
);

    if (LOCK_MAX < 1 || LOCK_MAX > 65535) begin : g_bad_lock_max
        $error("LOCK_MAX must fit the 16-bit lock counter");
    end

    state_t             state_q, state_d;
    owner_t             last_q, last_d;
    logic               cpu_rvalid_q, dma_rvalid_q;
    logic [BUS_W-1:0]   cpu_hold_q, dma_hold_q;
    logic               cpu_gnt, dma_gnt;
    logic               lock_expired;

    // Outputs are forced quiet for every cycle RESET is high, including the
    // first one before the registers have been cleared.
    assign cpu_gnt = (state_q == OWN_CPU) && bus_io.cpu_req && !RESET;
    assign dma_gnt = (state_q == OWN_DMA) && bus_io.dma_req && !RESET;

    assign bus_io.cpu_gnt   = cpu_gnt;
    assign bus_io.dma_gnt   = dma_gnt;
    assign bus_io.mem_en    = cpu_gnt || dma_gnt;
    assign bus_io.mem_we    = (cpu_gnt && bus_io.cpu_we) || (dma_gnt && bus_io.dma_we);
    assign bus_io.mem_addr  = cpu_gnt ? bus_io.cpu_addr  : (dma_gnt ? bus_io.dma_addr  : '0);
    assign bus_io.mem_wdata = cpu_gnt ? bus_io.cpu_wdata : (dma_gnt ? bus_io.dma_wdata : '0);

    // Read data passes straight from the memory in the rvalid cycle and is
    // held afterwards.
    assign bus_io.cpu_rvalid = cpu_rvalid_q && !RESET;
    assign bus_io.dma_rvalid = dma_rvalid_q && !RESET;
    assign bus_io.cpu_rdata  = RESET ? '0 : (cpu_rvalid_q ? bus_io.mem_rdata : cpu_hold_q);
    assign bus_io.dma_rdata  = RESET ? '0 : (dma_rvalid_q ? bus_io.mem_rdata : dma_hold_q);

    assign state_o = state_q;

`ifdef MEM_ARB_LOCK_TIMEOUT_EN
    logic force_sw;
    logic timeout_q;

    mem_arb_lock_timer #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_timer (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear_i   ((state_d != state_q) || (state_q == IDLE)),
        .lock_i    (((state_q == OWN_CPU) && bus_io.cpu_lock) ||
                    ((state_q == OWN_DMA) && bus_io.dma_lock)),
        .expired_o (lock_expired)
    );

    // A forced switch is a locked owner leaving because the limit expired.
    assign force_sw = ((state_q == OWN_CPU) && bus_io.cpu_req && bus_io.cpu_lock &&
                       lock_expired && bus_io.dma_req) ||
                      ((state_q == OWN_DMA) && bus_io.dma_req && bus_io.dma_lock &&
                       lock_expired && bus_io.cpu_req);
    assign bus_io.lock_timeout = timeout_q && !RESET;
`else
    assign lock_expired        = 1'b0;
    assign bus_io.lock_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus_io.cpu_req && bus_io.dma_req) begin
                    state_d = (last_q == OWNER_DMA) ? OWN_CPU : OWN_DMA;
                end else if (bus_io.cpu_req) begin
                    state_d = OWN_CPU;
                end else if (bus_io.dma_req) begin
                    state_d = OWN_DMA;
                end
            end
            OWN_CPU: begin
                if (bus_io.cpu_req && bus_io.cpu_lock && !lock_expired) begin
                    state_d = OWN_CPU;
                end else if (bus_io.dma_req) begin
                    state_d = OWN_DMA;
                end else if (!bus_io.cpu_req) begin
                    state_d = IDLE;
                end
            end
            OWN_DMA: begin
                if (bus_io.dma_req && bus_io.dma_lock && !lock_expired) begin
                    state_d = OWN_DMA;
                end else if (bus_io.cpu_req) begin
                    state_d = OWN_CPU;
                end else if (!bus_io.dma_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == OWN_CPU && state_q != OWN_CPU) last_d = OWNER_CPU;
        if (state_d == OWN_DMA && state_q != OWN_DMA) last_d = OWNER_DMA;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            last_q       <= OWNER_DMA;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_hold_q   <= '0;
            dma_hold_q   <= '0;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cpu_rvalid_q <= cpu_gnt && !bus_io.cpu_we;
            dma_rvalid_q <= dma_gnt && !bus_io.dma_we;
            if (cpu_rvalid_q) cpu_hold_q <= bus_io.mem_rdata;
            if (dma_rvalid_q) dma_hold_q <= bus_io.mem_rdata;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
            timeout_q    <= force_sw;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios plus a randomized run for mem_bus_arbiter, checked against
// an ownership model kept in this file. Built with MEM_ARB_LOCK_TIMEOUT_EN
// defined, the arbiter uses LOCK_MAX=4 and the timeout scenario expects a
// forced release; otherwise it expects the DMA to keep the bus.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_LOCK_TIMEOUT_EN
    localparam int LMAX  = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int LMAX  = LOCK_MAX_DEF;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int BURST = TO_EN ? LMAX : 2048;
    localparam int W     = 2;

    // ---------------- clock / reset ----------------
    logic   CLK = 1'b0;
    logic   RESET = 1'b1;
    state_t dbg_state;

    always #5 CLK = ~CLK;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(
        .LOCK_MAX (LMAX)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus_io  (bus),
        .state_o (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // owner: 0 none, 1 CPU, 2 DMA
    int             m_own  = 0;
    int             m_last = 2;
    int             m_cnt  = 0;
    bit             m_to   = 1'b0;
    logic [15:0]    m_cpu_hold = '0;
    logic [15:0]    m_dma_hold = '0;
    logic [W-1:0]   exp_q[$];       // owner of the read whose data is due next cycle

    logic           e_cg, e_dg, e_en, e_we, e_cv, e_dv, e_to;
    logic [15:0]    e_addr, e_wd, e_cr, e_dr;
    logic           prev_cg = 1'b0, prev_dg = 1'b0;

    task automatic model_eval();
        logic [W-1:0] pend;
        pend   = (exp_q.size() > 0) ? exp_q[0] : 2'd0;
        e_cg   = !RESET && (m_own == 1) && bus.cpu_req;
        e_dg   = !RESET && (m_own == 2) && bus.dma_req;
        e_en   = e_cg || e_dg;
        e_we   = (e_cg && bus.cpu_we) || (e_dg && bus.dma_we);
        e_addr = e_cg ? bus.cpu_addr  : (e_dg ? bus.dma_addr  : 16'h0);
        e_wd   = e_cg ? bus.cpu_wdata : (e_dg ? bus.dma_wdata : 16'h0);
        e_cv   = !RESET && (pend == 2'd1);
        e_dv   = !RESET && (pend == 2'd2);
        e_cr   = RESET ? 16'h0 : ((pend == 2'd1) ? bus.mem_rdata : m_cpu_hold);
        e_dr   = RESET ? 16'h0 : ((pend == 2'd2) ? bus.mem_rdata : m_dma_hold);
        e_to   = !RESET && m_to;
    endtask

    task automatic model_clock();
        logic [W-1:0] p;
        bit xr, xl, orq, forced;
        int nxt;
        if (RESET) begin
            m_own = 0; m_last = 2; m_cnt = 0; m_to = 1'b0;
            m_cpu_hold = '0; m_dma_hold = '0;
            exp_q.delete();
            return;
        end
        model_eval();
        if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            if (p == 2'd1) m_cpu_hold = bus.mem_rdata;
            else           m_dma_hold = bus.mem_rdata;
        end
        if (e_cg && !bus.cpu_we) exp_q.push_back(2'd1);
        if (e_dg && !bus.dma_we) exp_q.push_back(2'd2);
        forced = 1'b0;
        xl     = 1'b0;
        if (m_own == 0) begin
            if (bus.cpu_req && bus.dma_req) nxt = (m_last == 2) ? 1 : 2;
            else if (bus.cpu_req)           nxt = 1;
            else if (bus.dma_req)           nxt = 2;
            else                            nxt = 0;
        end else begin
            xr  = (m_own == 1) ? bus.cpu_req  : bus.dma_req;
            xl  = (m_own == 1) ? bus.cpu_lock : bus.dma_lock;
            orq = (m_own == 1) ? bus.dma_req  : bus.cpu_req;
            forced = TO_EN && xr && xl && orq && (m_cnt + 1 >= LMAX);
            if (xr && xl && !forced) nxt = m_own;
            else if (orq)            nxt = 3 - m_own;
            else if (xr)             nxt = m_own;
            else                     nxt = 0;
        end
        if (nxt == 0 || nxt != m_own) m_cnt = 0;
        else if (xl)                  m_cnt = m_cnt + 1;
        else                          m_cnt = 0;
        if (nxt != 0 && nxt != m_own) m_last = nxt;
        m_to  = forced;
        m_own = nxt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_lock = 1'b0;
        bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_lock = 1'b0;
        bus.dma_addr = '0;  bus.dma_wdata = '0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [39:0] obs;
        idle_inputs();
        RESET = 1'b1;
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        bus.cpu_addr = 16'h1111; bus.dma_addr = 16'h2222;
        bus.cpu_wdata = 16'h3333; bus.dma_wdata = 16'h4444;
        bus.mem_rdata = 16'h5A5A;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            obs = {bus.cpu_gnt, bus.dma_gnt, bus.mem_en, bus.mem_we, bus.cpu_rvalid,
                   bus.dma_rvalid, bus.lock_timeout, 1'b0, bus.mem_addr, bus.mem_wdata};
            n_tests++;
            if (obs !== 40'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, obs);
            end
            n_tests++;
            if ({bus.cpu_rdata, bus.dma_rdata} !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata cycle %0d: got %h expected 0", c, {bus.cpu_rdata, bus.dma_rdata});
            end
            if (c > 0) begin
                n_tests++;
                if (dbg_state !== IDLE) begin
                    n_fail++;
                    $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
                end
            end
            step();
        end
        idle_inputs();
        RESET = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        @(negedge CLK);
        n_tests++;
        if ({bus.cpu_gnt, bus.mem_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL read_first_cycle: got %b expected 00", {bus.cpu_gnt, bus.mem_en});
        end
        step();
        @(negedge CLK);
        n_tests++;
        if ({bus.cpu_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b110, 16'h0010}) begin
            n_fail++;
            $display("FAIL read_grant: got %h expected %h",
                     {bus.cpu_gnt, bus.mem_en, bus.mem_we, bus.mem_addr}, {3'b110, 16'h0010});
        end
        step();
        bus.cpu_req = 1'b0;
        bus.mem_rdata = 16'hBEEF;
        @(negedge CLK);
        n_tests++;
        if ({bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_gnt} !== {1'b1, 16'hBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL read_data: got %h expected %h",
                     {bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_gnt}, {1'b1, 16'hBEEF, 1'b0});
        end
        step();
        bus.mem_rdata = 16'h1234;
        @(negedge CLK);
        n_tests++;
        if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL read_hold: got %h expected %h", {bus.cpu_rvalid, bus.cpu_rdata}, {1'b0, 16'hBEEF});
        end
        step();
    endtask

    task automatic test_tie();
        logic [1:0] exp;
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_lock = 1'b1; bus.cpu_we = 1'b1;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 4) bus.cpu_lock = 1'b0;
            exp = {(c >= 2 && c <= 4), (c == 5)};
            @(negedge CLK);
            n_tests++;
            if ({bus.cpu_gnt, bus.dma_gnt} !== exp) begin
                n_fail++;
                $display("FAIL tie_cycle%0d: got %b expected %b", c, {bus.cpu_gnt, bus.dma_gnt}, exp);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_locked_burst();
        logic [18:0] exp;
        int errs;
        do_reset();
        bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_we = 1'b1;
        bus.dma_addr = 16'hA000;
        step();
        errs = 0;
        for (int i = 0; i < BURST; i++) begin
            bus.cpu_req   = 1'b1;
            bus.dma_addr  = 16'hA000 + 16'(i);
            bus.dma_wdata = 16'(i);
            bus.dma_lock  = (i != BURST - 1);
            exp = {3'b011, 16'hA000 + 16'(i)};
            @(negedge CLK);
            n_tests++;
            if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_we, bus.mem_addr} !== exp) begin
                n_fail++;
                errs++;
                if (errs < 5)
                    $display("FAIL burst_write %0d: got %h expected %h", i,
                             {bus.cpu_gnt, bus.dma_gnt, bus.mem_we, bus.mem_addr}, exp);
            end
            step();
        end
        bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
        @(negedge CLK);
        n_tests++;
        if ({bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout} !== 3'b100) begin
            n_fail++;
            $display("FAIL burst_handover: got %b expected 100", {bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout});
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_timeout();
        int nwait;
        nwait = TO_EN ? LMAX : 24;
        do_reset();
        bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_we = 1'b1;
        step();
        for (int i = 0; i < nwait; i++) begin
            bus.cpu_req = 1'b1;
            @(negedge CLK);
            n_tests++;
            if ({bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout} !== 3'b010) begin
                n_fail++;
                $display("FAIL timeout_hold %0d: got %b expected 010", i,
                         {bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout});
            end
            step();
        end
        @(negedge CLK);
        n_tests++;
        if ({bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout} !== (TO_EN ? 3'b101 : 3'b010)) begin
            n_fail++;
            $display("FAIL timeout_release: got %b expected %b",
                     {bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout}, (TO_EN ? 3'b101 : 3'b010));
        end
        step();
        @(negedge CLK);
        n_tests++;
        if ({bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout} !== 3'b010) begin
            n_fail++;
            $display("FAIL timeout_after: got %b expected 010", {bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout});
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0200;
        step();
        @(negedge CLK);
        n_tests++;
        if ({bus.dma_gnt, bus.mem_en, bus.mem_we} !== 3'b110) begin
            n_fail++;
            $display("FAIL midread_grant: got %b expected 110", {bus.dma_gnt, bus.mem_en, bus.mem_we});
        end
        step();
        RESET = 1'b1;
        bus.mem_rdata = 16'h5555;
        @(negedge CLK);
        n_tests++;
        if ({bus.dma_rvalid, bus.dma_gnt, bus.mem_en, bus.mem_addr, bus.dma_rdata} !== 35'h0) begin
            n_fail++;
            $display("FAIL midread_in_reset: got %h expected 0",
                     {bus.dma_rvalid, bus.dma_gnt, bus.mem_en, bus.mem_addr, bus.dma_rdata});
        end
        step();
        RESET = 1'b0;
        @(negedge CLK);
        n_tests++;
        if ({dbg_state, bus.dma_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
            {IDLE, 3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL midread_after: got %h expected %h",
                     {dbg_state, bus.dma_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                     {IDLE, 3'b000, 32'h0});
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        do_reset();
        prev_cg = 1'b0;
        prev_dg = 1'b0;
        for (int c = 0; c < 600; c++) begin
            RESET = ($urandom_range(0, 79) == 0);
            if (!bus.cpu_req || prev_cg) begin
                bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 16'($urandom);
            end
            if (!bus.dma_req || prev_dg) begin
                bus.dma_addr = 16'($urandom); bus.dma_wdata = 16'($urandom);
            end
            bus.cpu_req  = ($urandom_range(0, 3) != 0);
            bus.cpu_we   = 1'($urandom_range(0, 1));
            bus.cpu_lock = ($urandom_range(0, 2) == 0);
            bus.dma_req  = ($urandom_range(0, 3) != 0);
            bus.dma_we   = 1'($urandom_range(0, 1));
            bus.dma_lock = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = 16'($urandom);
            @(negedge CLK);
            model_eval();
            n_tests++;
            if ({bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout} !== {e_cg, e_dg, e_to}) begin
                n_fail++;
                $display("FAIL rand_gnt cycle %0d: got %b expected %b", c,
                         {bus.cpu_gnt, bus.dma_gnt, bus.lock_timeout}, {e_cg, e_dg, e_to});
            end
            n_tests++;
            if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {e_en, e_we, e_addr, e_wd}) begin
                n_fail++;
                $display("FAIL rand_mem cycle %0d: got %h expected %h", c,
                         {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {e_en, e_we, e_addr, e_wd});
            end
            n_tests++;
            if ({bus.cpu_rvalid, bus.cpu_rdata} !== {e_cv, e_cr}) begin
                n_fail++;
                $display("FAIL rand_cpu_read cycle %0d: got %h expected %h", c,
                         {bus.cpu_rvalid, bus.cpu_rdata}, {e_cv, e_cr});
            end
            n_tests++;
            if ({bus.dma_rvalid, bus.dma_rdata} !== {e_dv, e_dr}) begin
                n_fail++;
                $display("FAIL rand_dma_read cycle %0d: got %h expected %h", c,
                         {bus.dma_rvalid, bus.dma_rdata}, {e_dv, e_dr});
            end
            prev_cg = e_cg;
            prev_dg = e_dg;
            step();
        end
        RESET = 1'b0;
        idle_inputs();
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_locked_burst();
        test_timeout();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
